// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg : shared definitions for the multi-cycle execute-stage ALU.
//   alu_op_e    - 3-bit ALU_op encoding
//   FLAG_*      - bit positions inside the 4-bit flags word {N, Z, INV, V}
//   alu_state_e - control FSM states of alu_seq
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_MUL  = 3'b100,
        OP_DIV  = 3'b101,
        OP_NOTB = 3'b110,
        OP_XOR  = 3'b111
    } alu_op_e;

    // Flag positions line up with CPSR bits 31:28 once shifted into place.
    localparam int FLAG_N   = 3;
    localparam int FLAG_Z   = 2;
    localparam int FLAG_INV = 1;
    localparam int FLAG_V   = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } alu_state_e;

endpackage

// File: rtl/alu_seq_div.sv
// ---------------------------------------------------------------------------
// alu_seq_div : iterative unsigned restoring divider, one quotient bit per
// cycle, WIDTH cycles per division.
//   clk_i, rst_i   - clock, synchronous active-high reset (aborts a division)
//   start_i        - load dividend/divisor magnitudes and begin
//   dividend_i     - dividend magnitude
//   divisor_i      - divisor magnitude (non-zero; zero is filtered upstream)
//   done_o         - high during the cycle that produces the last quotient bit
//   quot_o         - quotient, valid while done_o is high
// ---------------------------------------------------------------------------
module alu_seq_div
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             done_o,
    output logic [WIDTH-1:0] quot_o
);

    localparam int CW = $clog2(WIDTH + 1);

    logic             busy_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dq_q;   // dividend shifts out the top, quotient in the bottom
    logic [WIDTH-1:0] dvs_q;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] diff;
    logic             qbit;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] dq_d;

    always_comb begin
        rem_sh = {rem_q, dq_q[WIDTH-1]};
        diff   = {1'b0, rem_sh} - {2'b00, dvs_q};
        qbit   = ~diff[WIDTH+1];               // no borrow: divisor fits
        rem_d  = qbit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        dq_d   = {dq_q[WIDTH-2:0], qbit};
    end

    // The final step's quotient is presented combinationally so the caller can
    // register the signed result on the same edge that retires the last bit.
    assign done_o = busy_q && (cnt_q == CW'(1));
    assign quot_o = dq_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            dq_q   <= '0;
            dvs_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= CW'(WIDTH);
            rem_q  <= '0;
            dq_q   <= dividend_i;
            dvs_q  <= divisor_i;
        end else if (busy_q) begin
            rem_q <= rem_d;
            dq_q  <= dq_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq : multi-cycle execute-stage ALU with valid/ready on both sides.
// ADD/SUB/logic ops and DIV-by-zero finish in one cycle; MUL (iterative
// shift-add) and DIV (restoring, alu_seq_div) take WIDTH+1 cycles.
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready   - request handshake (in_ready depends on out_ready)
//   val_A, val_B        - signed operands
//   ALU_op              - operation, see alu_op_e
//   out_valid/out_ready - result handshake
//   ALU_out             - result
//   flags               - {N, Z, INV, V}
// Build option: ALU_SEQ_FAST_MUL_EN - MUL uses a single-cycle signed '*'
// and never enters the MUL state.
// ---------------------------------------------------------------------------
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] val_A,
    input  logic [WIDTH-1:0] val_B,
    input  logic [2:0]       ALU_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_out,
    output logic [3:0]       flags
);

    localparam int CW = $clog2(WIDTH + 1);

    alu_state_e         state_q, state_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [3:0]         flags_q, flags_d;
    logic [2*WIDTH-1:0] p_q, p_d;          // {accumulator, remaining multiplier}
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic               sign_q, sign_d;    // sign of the MUL/DIV result
    logic [CW-1:0]      cnt_q, cnt_d;

    logic               accept;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   add_r, sub_r;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] p_step, prod_s;
    logic               div_start, div_done;
    logic [WIDTH-1:0]   div_quot, quot_s;
`ifdef ALU_SEQ_FAST_MUL_EN
    logic [2*WIDTH-1:0] fprod;
`endif

    function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r,
                                            input logic inv, input logic v);
        logic [3:0] f;
        f           = '0;
        f[FLAG_N]   = r[WIDTH-1];
        f[FLAG_Z]   = (r == '0);
        f[FLAG_INV] = inv;
        f[FLAG_V]   = v;
        return f;
    endfunction

    assign out_valid = (state_q == ST_DONE);
    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign ALU_out   = res_q;
    assign flags     = flags_q;

    // |MIN| wraps to MIN, which is the correct magnitude read as unsigned.
    assign a_mag = val_A[WIDTH-1] ? -val_A : val_A;
    assign b_mag = val_B[WIDTH-1] ? -val_B : val_B;
    assign add_r = val_A + val_B;
    assign sub_r = val_A - val_B;

    // One shift-add step: add multiplicand to the upper half when the current
    // multiplier bit is set, then shift the whole register right.
    assign mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, mcand_q} : '0);
    assign p_step  = {mul_sum, p_q[WIDTH-1:1]};
    assign prod_s  = sign_q ? -p_step : p_step;
    assign quot_s  = sign_q ? -div_quot : div_quot;

`ifdef ALU_SEQ_FAST_MUL_EN
    assign fprod = $signed({{WIDTH{val_A[WIDTH-1]}}, val_A}) *
                   $signed({{WIDTH{val_B[WIDTH-1]}}, val_B});
`endif

    alu_seq_div #(.WIDTH(WIDTH)) u_div (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (div_start),
        .dividend_i (a_mag),
        .divisor_i  (b_mag),
        .done_o     (div_done),
        .quot_o     (div_quot)
    );

    always_comb begin
        state_d   = state_q;
        res_d     = res_q;
        flags_d   = flags_q;
        p_d       = p_q;
        mcand_d   = mcand_q;
        sign_d    = sign_q;
        cnt_d     = cnt_q;
        div_start = 1'b0;

        case (state_q)
            ST_MUL: begin
                p_d   = p_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    res_d   = prod_s[WIDTH-1:0];
                    flags_d = mk_flags(prod_s[WIDTH-1:0], 1'b0,
                                       prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});
                    state_d = ST_DONE;
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    // Only MIN / -1 yields a positive quotient with the MSB set.
                    res_d   = quot_s;
                    flags_d = mk_flags(quot_s, 1'b0, !sign_q && div_quot[WIDTH-1]);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: ;
        endcase

        // Accepts happen only from IDLE or a draining DONE, so this override
        // never collides with an in-flight MUL/DIV.
        if (accept) begin
            sign_d  = val_A[WIDTH-1] ^ val_B[WIDTH-1];
            state_d = ST_DONE;
            case (alu_op_e'(ALU_op))
                OP_ADD: begin
                    res_d   = add_r;
                    flags_d = mk_flags(add_r, 1'b0,
                                       (val_A[WIDTH-1] == val_B[WIDTH-1]) &&
                                       (add_r[WIDTH-1] != val_A[WIDTH-1]));
                end
                OP_SUB: begin
                    res_d   = sub_r;
                    flags_d = mk_flags(sub_r, 1'b0,
                                       (val_A[WIDTH-1] != val_B[WIDTH-1]) &&
                                       (sub_r[WIDTH-1] != val_A[WIDTH-1]));
                end
                OP_AND: begin
                    res_d   = val_A & val_B;
                    flags_d = mk_flags(val_A & val_B, 1'b0, 1'b0);
                end
                OP_OR: begin
                    res_d   = val_A | val_B;
                    flags_d = mk_flags(val_A | val_B, 1'b0, 1'b0);
                end
                OP_XOR: begin
                    res_d   = val_A ^ val_B;
                    flags_d = mk_flags(val_A ^ val_B, 1'b0, 1'b0);
                end
                OP_NOTB: begin
                    res_d   = ~val_B;
                    flags_d = mk_flags(~val_B, 1'b0, 1'b0);
                end
                OP_MUL: begin
`ifdef ALU_SEQ_FAST_MUL_EN
                    res_d   = fprod[WIDTH-1:0];
                    flags_d = mk_flags(fprod[WIDTH-1:0], 1'b0,
                                       fprod[2*WIDTH-1:WIDTH] != {WIDTH{fprod[WIDTH-1]}});
`else
                    state_d = ST_MUL;
                    mcand_d = a_mag;
                    p_d     = {{WIDTH{1'b0}}, b_mag};
                    cnt_d   = CW'(WIDTH);
`endif
                end
                OP_DIV: begin
                    if (val_B == '0) begin
                        res_d   = '0;
                        flags_d = mk_flags('0, 1'b1, 1'b0);
                    end else begin
                        state_d   = ST_DIV;
                        div_start = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            res_q   <= '0;
            flags_q <= '0;
            p_q     <= '0;
            mcand_q <= '0;
            sign_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            p_q     <= p_d;
            mcand_q <= mcand_d;
            sign_q  <= sign_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq : self-checking bench for alu_seq (WIDTH = 32).
// A vector table drives one op at a time; a negedge monitor pops expected
// results from a scoreboard queue on every out_valid && out_ready.
// Hand-written sequences cover back-to-back ops, output hold and reset abort.
// ---------------------------------------------------------------------------
module tb_alu_seq;

    localparam int W = 32;
`ifdef ALU_SEQ_FAST_MUL_EN
    localparam int ML = 1;
`else
    localparam int ML = W + 1;
`endif
    localparam int DL = W + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  val_A, val_B;
    logic [2:0]    ALU_op;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  ALU_out;
    logic [3:0]    flags;

    typedef struct packed {
        logic [W-1:0] res;
        logic [3:0]   flg;
    } exp_t;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [3:0]   flg;
        int           lat;
    } vec_t;

    exp_t sbq[$];
    vec_t vt[16];
    int   checks = 0;
    int   errors = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .val_A     (val_A),
        .val_B     (val_B),
        .ALU_op    (ALU_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALU_out   (ALU_out),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every handshaken output must match the oldest entry.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                chk("unexpected_out", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("sb_res", ALU_out, e.res);
                chk("sb_flags", 32'(flags), 32'(e.flg));
            end
        end
    end

    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] res, input logic [3:0] f, input int lat,
                          input string nm);
        int n;
        @(negedge clk);
        ALU_op   = op;
        val_A    = a;
        val_B    = b;
        in_valid = 1'b1;
        sbq.push_back(exp_t'({res, f}));
        chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, 32'(n + 1), 32'(lat));
    endtask

    initial begin
        logic ov;
        // {op, A, B, result, {N,Z,INV,V}, latency}
        vt[0]  = '{3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001, 1};
        vt[1]  = '{3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0100, 1};
        vt[2]  = '{3'b001, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0001, 1};
        vt[3]  = '{3'b001, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 4'b1000, 1};
        vt[4]  = '{3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b1000, 1};
        vt[5]  = '{3'b011, 32'h000000F0, 32'h0000000F, 32'h000000FF, 4'b0000, 1};
        vt[6]  = '{3'b110, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 4'b1000, 1};
        vt[7]  = '{3'b111, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 4'b0100, 1};
        vt[8]  = '{3'b100, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 4'b1000, ML};
        vt[9]  = '{3'b100, 32'h00010000, 32'h00010000, 32'h00000000, 4'b0101, ML};
        vt[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b1001, ML};
        vt[11] = '{3'b101, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 4'b1000, DL};
        vt[12] = '{3'b101, 32'h00000009, 32'h00000000, 32'h00000000, 4'b0110, 1};
        vt[13] = '{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b1001, DL};
        vt[14] = '{3'b101, 32'h00000064, 32'h00000007, 32'h0000000E, 4'b0000, DL};
        vt[15] = '{3'b101, 32'h00000003, 32'hFFFFFFFB, 32'h00000000, 4'b0100, DL};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        val_A = '0; val_B = '0; ALU_op = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_ALU_out", ALU_out, 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 16; i++)
            run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].res, vt[i].flg, vt[i].lat,
                   $sformatf("vec%0d", i));

        // Back-to-back: SUB then XOR on consecutive cycles.
        @(negedge clk);
        ALU_op = 3'b001; val_A = 32'd5; val_B = 32'd5; in_valid = 1'b1;
        sbq.push_back(exp_t'({32'h0, 4'b0100}));
        @(posedge clk);
        #1 ALU_op = 3'b111; val_A = 32'hF0F0F0F0; val_B = 32'hFFFFFFFF;
        sbq.push_back(exp_t'({32'h0F0F0F0F, 4'b0000}));
        @(negedge clk);
        chk("b2b_sub_valid", 32'(out_valid), 32'd1);
        chk("b2b_sub_res", ALU_out, 32'h0);
        chk("b2b_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_xor_valid", 32'(out_valid), 32'd1);
        chk("b2b_xor_res", ALU_out, 32'h0F0F0F0F);

        // Output hold with out_ready low, pending request waits, then goes.
        @(negedge clk);
        out_ready = 1'b0;
        ALU_op = 3'b000; val_A = 32'd1; val_B = 32'd2; in_valid = 1'b1;
        sbq.push_back(exp_t'({32'd3, 4'b0000}));
        @(posedge clk);
        #1 ALU_op = 3'b011; val_A = 32'h30; val_B = 32'h0C;
        sbq.push_back(exp_t'({32'h3C, 4'b0000}));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_res", ALU_out, 32'd3);
            chk("hold_flags", 32'(flags), 32'd0);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("release_next_valid", 32'(out_valid), 32'd1);
        chk("release_next_res", ALU_out, 32'h3C);

        // Reset 10 cycles into a DIV: no result ever appears.
        @(negedge clk);
        ALU_op = 3'b101; val_A = 32'd100; val_B = 32'd3; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        ov = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) ov = 1'b1;
        end
        chk("abort_no_valid", 32'(ov), 32'd0);
        run_op(3'b000, 32'd2, 32'd2, 32'd4, 4'b0000, 1, "after_abort");

        @(negedge clk);
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the combinational execute-stage ALU. It accepts one operation per valid/ready handshake and completes logic and add/sub operations in one cycle. Signed multiply and divide use iterative datapaths, so the CPU can stall on `in_ready`/`out_valid` instead of synthesising a full-width combinational divider. It sits between operand fetch and writeback in the ARM32CPU execute stage.

## Interface
- `WIDTH`, 32: operand and result width (≥ 8).
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operands and op are valid.
- `in_ready` output 1: block can accept a request this cycle.
- `val_A` input WIDTH: operand A (signed).
- `val_B` input WIDTH: operand B (signed).
- `ALU_op` input 3: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 MUL, 101 DIV, 110 NOT B, 111 XOR.
- `out_valid` output 1: result and flags are valid.
- `out_ready` input 1: consumer accepts the result.
- `ALU_out` output WIDTH: result.
- `flags` output 4: {N, Z, INV, V}, matching CPSR bits 31:28.

## Operation
- States: IDLE, MUL, DIV, DONE. Request accepted when `in_valid && in_ready`; operands and op are registered.
- Accept in IDLE:
  - ADD/SUB/AND/OR/NOT/XOR: result computed and registered; next state DONE.
  - MUL: next state MUL; loads |A|, |B|, 2·WIDTH accumulator, counter = WIDTH.
  - DIV with B == 0: result 0, INV = 1; next state DONE directly.
  - DIV otherwise: next state DIV; restoring division on |A|, |B|, counter = WIDTH.
- MUL and DIV each do one shift-add or shift-subtract step per cycle. When the counter reaches 0, apply sign (A_sign ^ B_sign), register the result, and go to DONE.
- DONE: `out_valid` = 1; outputs stay stable until `out_ready`. On `out_ready`, go to IDLE, or directly to the next request if one is accepted in the same cycle.
- `in_ready` = (state == IDLE) || (state == DONE && out_ready). This is a combinational path from `out_ready`.
- Arithmetic rules, all mod 2^WIDTH, two's complement:
  - ADD: V = A and B same sign, result sign differs.
  - SUB: V = A and B differ in sign, and result sign ≠ A sign.
  - MUL: result = low WIDTH bits. V = 1 unless the full 2·WIDTH product is the sign-extension of its low half.
  - DIV: truncates toward zero. MIN / −1 gives MIN with V = 1.
  - Logic ops: V = 0, INV = 0.
- N = result MSB; Z = (result == 0), evaluated on the final result for every op.
- `ALU_op` and operands are ignored when no request is accepted.

## Timing
- Reset values: `out_valid` = 0, `ALU_out` = 0, `flags` = 0, state IDLE, counter 0. `in_ready` = 1 from the first cycle after reset.
- Single-cycle ops and DIV-by-zero: accept at cycle t, `out_valid` at t+1.
- MUL and DIV (non-zero divisor): accept at t, `out_valid` at t+WIDTH+1.
- Back-to-back throughput for single-cycle ops is 1 per cycle while `out_ready` is held high.
- Reset asserted mid-operation aborts the operation. No `out_valid` pulse follows; state returns to IDLE next cycle.
- While `out_valid && !out_ready`, `ALU_out`/`flags` do not change and `in_ready` = 0.

## Configuration
- `ALU_SEQ_FAST_MUL_EN` defined: MUL uses a single-cycle `*` on signed operands. State MUL is unused, and MUL latency is 1 like the logic ops.
- Undefined (default): MUL uses the iterative shift-add path with WIDTH+1 latency.
- Flags and overflow semantics are identical in both builds.

## Structure
- Package `alu_pkg`:
  - op encoding enum `alu_op_e`
  - flag index constants (`FLAG_N` = 3, `FLAG_Z` = 2, `FLAG_INV` = 1, `FLAG_V` = 0)
  - state enum `alu_state_e`
- Sub-module `alu_seq_div`: the iterative restoring divider with start/done, magnitude in and quotient out. It is instantiated once. The multiplier stays inline in `alu_seq`.

## Test plan
- ADD 0x7FFFFFFF + 1 -> `ALU_out` 0x80000000, flags N=1 Z=0 INV=0 V=1, `out_valid` 1 cycle after accept.
- SUB 5 − 5, then XOR 0xF0F0F0F0 ^ 0xFFFFFFFF back-to-back with `out_ready` high:
  - results 0 (Z=1) and 0x0F0F0F0F, on consecutive cycles.
- MUL −3 × 7 -> 0xFFFFFFEB, N=1, V=0, `out_valid` after 33 cycles. MUL 0x10000 × 0x10000 -> 0, Z=1, V=1.
- DIV −7 / 2 -> 0xFFFFFFFD (−3). DIV 9 / 0 -> 0, INV=1, Z=1, latency 1. DIV 0x80000000 / −1 -> 0x80000000, V=1.
- Hold `out_ready` = 0 for 5 cycles after a result -> outputs stable, `in_ready` = 0; release -> accepted same cycle.
- Assert `rst` 10 cycles into a DIV -> `out_valid` never rises; `in_ready` = 1 the next cycle. A new ADD 2+2 returns 4.
